regbank16_write_32bit: RTL and testbench

- Write-side companion to the 16:1 32-bit read-select path.
- Holds sixteen 32-bit registers and decodes a 4-bit write address into per-register, per-byte enables.
- Exposes all sixteen registers as one flat bus that feeds the read-select mux directly.
- Adds a sequenced bulk-clear engine with a ready/valid write handshake so software-visible state can be wiped without a reset.

---
 rtl/regbank16_write_32bit.sv | 115 +++++++++++
 tb/tb_regbank16_write_32bit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank16_write_32bit.sv
// Write side of a sixteen-entry register bank: byte-enabled writes, flat readout, bulk-clear sweep.
// Optional macro REGBANK_ZERO_REG_EN makes register 0 a hard-wired zero.
module regbank16_write_32bit #(
  parameter int               WIDTH   = 32,
  parameter int               NREG    = 16,
  parameter logic [WIDTH-1:0] CLR_VAL = 32'h0000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [3:0]              wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [WIDTH/8-1:0]      wr_be,
  output logic                    wr_ack,
  input  logic                    clr_req,
  output logic                    busy,
  output logic [3:0]              clr_idx,
  output logic [NREG*WIDTH-1:0]   q_flat
);

  localparam int         NBYTE = WIDTH / 8;
  localparam logic [3:0] LAST  = 4'(NREG - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       clr_idx_q, clr_idx_d;
  logic             wr_ack_q, wr_ack_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             wr_accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      wr_ack_q  <= 1'b0;
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_ack_q  <= wr_ack_d;
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    wr_accept = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      regs_d[k] = regs_q[k];
    end

    unique case (state_q)
      IDLE: begin
        wr_ready  = 1'b1;
        wr_accept = wr_valid;
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        busy              = 1'b1;
        regs_d[clr_idx_q] = CLR_VAL;
        clr_idx_d         = clr_idx_q + 4'd1;
        if (clr_idx_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Writes only land in IDLE, so they never collide with a sweep store.
    if (wr_accept) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (wr_be[b]) begin
          regs_d[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end

`ifdef REGBANK_ZERO_REG_EN
    regs_d[0] = '0;
`endif
  end

  assign wr_ack_d = wr_accept;
  assign wr_ack   = wr_ack_q;
  assign clr_idx  = clr_idx_q;

  for (genvar k = 0; k < NREG; k++) begin : g_flat
`ifdef REGBANK_ZERO_REG_EN
    if (k == 0) begin : g_zero
      assign q_flat[WIDTH-1:0] = '0;
    end else begin : g_reg
      assign q_flat[WIDTH*k +: WIDTH] = regs_q[k];
    end
`else
    assign q_flat[WIDTH*k +: WIDTH] = regs_q[k];
`endif
  end

endmodule

// File: tb/tb_regbank16_write_32bit.sv
// Directed bench for regbank16_write_32bit: writes, byte enables, clear sweeps, async reset.
module tb_regbank16_write_32bit;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [3:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic [3:0]   wr_be = '0;
  logic         wr_ack;
  logic         clr_req = 1'b0;
  logic         busy;
  logic [3:0]   clr_idx;
  logic [511:0] q_flat;

  int errors = 0;
  int checks = 0;
  logic [31:0] mreg [16];

`ifdef REGBANK_ZERO_REG_EN
  localparam logic [31:0] REG0_AFTER_ONES = 32'h0000_0000;
`else
  localparam logic [31:0] REG0_AFTER_ONES = 32'hFFFF_FFFF;
`endif

  regbank16_write_32bit dut (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .wr_ack   (wr_ack),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_idx  (clr_idx),
    .q_flat   (q_flat)
  );

  always #5 clock = ~clock;

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkf(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int k = 0; k < 16; k++) f[32*k +: 32] = mreg[k];
    return f;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) mreg[k] = '0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) mreg[a][8*b +: 8] = d[8*b +: 8];
`ifdef REGBANK_ZERO_REG_EN
    mreg[0] = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    tick();
    wr_valid = 1'b0;
    model_write(a, d, be);
    chkw("write_ack", 32'(wr_ack), 32'd1);
    chkf("write_flat", q_flat, model_flat());
  endtask

  initial begin
    model_clear();

    // Reset state
    tick();
    tick();
    chkf("rst_flat", q_flat, '0);
    chkw("rst_ready", 32'(wr_ready), 32'd1);
    chkw("rst_ack", 32'(wr_ack), 32'd0);
    chkw("rst_busy", 32'(busy), 32'd0);
    chkw("rst_idx", 32'(clr_idx), 32'd0);
    reset = 1'b0;
    tick();

    // Full write to register 5, one-cycle ack
    do_write(4'd5, 32'hDEADBEEF, 4'hF);
    chkw("lane5", q_flat[191:160], 32'hDEADBEEF);
    chkf("other_lanes_zero", q_flat & ~(512'hFFFF_FFFF << 160), '0);
    tick();
    chkw("ack_one_cycle", 32'(wr_ack), 32'd0);

    // Byte-enable merge and empty-enable write
    do_write(4'd3, 32'h11223344, 4'hF);
    do_write(4'd3, 32'hAABBCCDD, 4'b0101);
    chkw("lane3_merge", q_flat[127:96], 32'h11BB33DD);
    do_write(4'd3, 32'hFFFFFFFF, 4'h0);
    chkw("lane3_be0", q_flat[127:96], 32'h11BB33DD);

    // Register 0 behaviour depends on the build option
    do_write(4'd0, 32'hFFFFFFFF, 4'hF);
    chkw("lane0", q_flat[31:0], REG0_AFTER_ONES);

    // Fill, then sweep with a write held pending across it
    for (int k = 0; k < 16; k++) do_write(4'(k), 32'h1000_0000 + k, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 4'd7;
    wr_data  = 32'h77777777;
    wr_be    = 4'hF;
    for (int i = 0; i < 16; i++) begin
      chkw("sweep_busy", 32'(busy), 32'd1);
      chkw("sweep_idx", 32'(clr_idx), 32'(i));
      chkw("sweep_ready", 32'(wr_ready), 32'd0);
      chkw("sweep_noack", 32'(wr_ack), 32'd0);
      tick();
    end
    model_clear();
    chkw("sweep_done_busy", 32'(busy), 32'd0);
    chkw("sweep_done_ready", 32'(wr_ready), 32'd1);
    chkw("sweep_done_idx", 32'(clr_idx), 32'd0);
    chkf("sweep_all_zero", q_flat, '0);
    tick();
    wr_valid = 1'b0;
    model_write(4'd7, 32'h77777777, 4'hF);
    chkw("held_write_ack", 32'(wr_ack), 32'd1);
    chkf("held_write_flat", q_flat, model_flat());

    // Simultaneous write and clear request
    wr_valid = 1'b1;
    wr_addr  = 4'd15;
    wr_data  = 32'hCAFEF00D;
    wr_be    = 4'hF;
    clr_req  = 1'b1;
    tick();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    chkw("simul_ack", 32'(wr_ack), 32'd1);
    chkw("simul_lane15", q_flat[511:480], 32'hCAFEF00D);
    chkw("simul_busy", 32'(busy), 32'd1);
    chkw("simul_idx", 32'(clr_idx), 32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chkw("simul_hold15", q_flat[511:480], 32'hCAFEF00D);
    end
    tick();
    model_clear();
    chkw("simul_lane15_cleared", q_flat[511:480], 32'h0);
    chkw("simul_busy_done", 32'(busy), 32'd0);
    chkf("simul_all_zero", q_flat, '0);

    // Reset in the middle of a sweep
    for (int k = 0; k < 16; k++) do_write(4'(k), 32'h5A00_0000 + k, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    chkw("mid_idx", 32'(clr_idx), 32'd7);
    chkw("mid_lane6", q_flat[223:192], 32'h0);
    chkw("mid_lane8", q_flat[287:256], 32'h5A00_0008);
    reset = 1'b1;
    #1;
    model_clear();
    chkf("mid_rst_flat", q_flat, '0);
    chkw("mid_rst_busy", 32'(busy), 32'd0);
    chkw("mid_rst_ready", 32'(wr_ready), 32'd1);
    chkw("mid_rst_idx", 32'(clr_idx), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();

    // Reset while an ack is showing
    do_write(4'd2, 32'h12345678, 4'hF);
    reset = 1'b1;
    #1;
    model_clear();
    chkw("rst_drops_ack", 32'(wr_ack), 32'd0);
    chkf("rst_wipes_write", q_flat, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();

    // Held clear request: back-to-back sweeps with one IDLE cycle between
    clr_req = 1'b1;
    tick();
    chkw("b2b_first_busy", 32'(busy), 32'd1);
    repeat (16) tick();
    chkw("b2b_gap_busy", 32'(busy), 32'd0);
    chkw("b2b_gap_ready", 32'(wr_ready), 32'd1);
    tick();
    chkw("b2b_second_busy", 32'(busy), 32'd1);
    chkw("b2b_second_idx", 32'(clr_idx), 32'd0);
    clr_req = 1'b0;
    repeat (16) tick();
    chkw("b2b_end_busy", 32'(busy), 32'd0);
    chkw("b2b_end_ready", 32'(wr_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
